// File: rtl/mem_master_pkg.sv
// Shared types and defaults for the banked-memory initiator.
// Holds the FSM state encoding and default bus widths.
package mem_master_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = 6;
  localparam int MAX_RD_LAT = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_master_rd_valid_pipe.sv
// Shift register of read-valid tokens, one stage per cycle of read latency.
// Ports: clk, clear (sync), tok_in; tok_out = oldest stage, empty = no tokens.
module rd_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic clear,
  input  logic tok_in,
  output logic tok_out,
  output logic empty
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (clear) begin
      sr <= '0;
    end else begin
      sr[0] <= tok_in;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign tok_out = sr[DEPTH-1];
  assign empty   = ~|sr;

endmodule

// File: rtl/mem_master.sv
// Burst initiator for the 256x32 banked memory.
// Ports: host req_*/wdata_*/rdata_*/done side; mem_addr/mem_write/mem_wdata/mem_rdata to memory.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ready,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PIPE_D =
    (RD_LAT < 1) ? 1 :
    (RD_LAT > MAX_RD_LAT) ? MAX_RD_LAT : RD_LAT;
  localparam logic [ADDR_W-1:0] ONE_A = 1;
  localparam logic [LEN_W-1:0]  ONE_L = 1;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  cnt;
  logic [DATA_W-1:0] wdata_q;
  logic              consume;
  logic              issue;
  logic              last;
  logic              tok_out;
  logic              pipe_empty;

  assign consume = (state == WRITE) && wdata_valid;
  assign issue   = (state == READ);
  assign last    = (cnt == len);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = req_write ? WRITE : READ;
      WRITE:   if (consume && last) state_nxt = DONE;
      READ:    if (last) state_nxt = DRAIN;
      DRAIN:   if (pipe_empty) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    mem_write   = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE:  req_ready = 1'b1;
      WRITE: begin
        wdata_ready = 1'b1;
        mem_write   = wdata_valid;
      end
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // addr doubles as the memory address: loaded on accept so the
  // first read issue sees it in the very next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr        <= '0;
      len         <= '0;
      cnt         <= '0;
      wdata_q     <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= tok_out;
      if (tok_out) rdata <= mem_rdata;
      if (state == IDLE && req_valid) begin
        addr <= req_addr;
        len  <= req_len;
        cnt  <= '0;
      end else if (consume || issue) begin
        addr <= addr + ONE_A;
        cnt  <= cnt + ONE_L;
      end
      if (consume) wdata_q <= wdata;
    end
  end

  assign mem_addr = addr;
  // Live beat goes straight to memory; otherwise hold the last one.
  assign mem_wdata = consume ? wdata : wdata_q;

  rd_valid_pipe #(
    .DEPTH(PIPE_D)
  ) u_pipe (
    .clk    (clk),
    .clear  (reset),
    .tok_in (issue),
    .tok_out(tok_out),
    .empty  (pipe_empty)
  );

endmodule
